// File: rtl/multicycle_control.sv
// multicycle_control
//   Main control FSM for a multicycle MIPS-style datapath. One state per
//   instruction step; every datapath control is a combinational decode of
//   the current state plus the live opcode/funct/zero/mem_ready inputs, so
//   handshake-dependent strobes (irwrite, pcen) respond in the same cycle.
//
// Ports
//   clk         sole clock, rising edge
//   reset       synchronous active-high reset, forces FETCH
//   opcode      instr[31:26] from the instruction register
//   funct       instr[5:0] from the instruction register
//   zero        ALU zero flag (branch decision)
//   mem_ready   completion strobe for the current memory access
//   iord, memread, memwrite, irwrite, pcen, regwrite, regdst, memtoreg,
//   alusrca, illegal_op            1-bit datapath controls / status
//   pcsrc       PC mux select   (00 ALU, 01 ALUOut, 10 jump target)
//   alusrcb     ALU B select    (00 rt, 01 4, 10 imm, 11 imm<<2)
//   alucontrol  ALU operation   (010 add, 110 sub, 000 and, 001 or, 111 slt)
//   state       current state encoding (debug)
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcen,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic       illegal_op,
  output logic [1:0] pcsrc,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t state_r;

  // R-type funct field to ALU operation; unknown functs fall back to add.
  function automatic logic [2:0] alu_decode(input logic [5:0] f);
    case (f)
      6'b100000: alu_decode = 3'b010;
      6'b100010: alu_decode = 3'b110;
      6'b100100: alu_decode = 3'b000;
      6'b100101: alu_decode = 3'b001;
      6'b101010: alu_decode = 3'b111;
      default:   alu_decode = 3'b010;
    endcase
  endfunction

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
      default:                                       op_legal = 1'b0;
    endcase
  endfunction

  // State register: reset overrides any pending transition, including
  // stalls in FETCH/MEMRD/MEMWR. Unused encodings recover to FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= FETCH;
    end else begin
      case (state_r)
        FETCH:    if (mem_ready) state_r <= DECODE;
        DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state_r <= MEMADR;
            OP_RTYPE:     state_r <= EXECUTE;
            OP_BEQ:       state_r <= BRANCH;
            OP_ADDI:      state_r <= ADDIEXEC;
            OP_J:         state_r <= JUMP;
            default:      state_r <= FETCH;
          endcase
        end
        MEMADR:   state_r <= (opcode == OP_SW) ? MEMWR : MEMRD;
        MEMRD:    if (mem_ready) state_r <= MEMWB;
        MEMWB:    state_r <= FETCH;
        MEMWR:    if (mem_ready) state_r <= FETCH;
        EXECUTE:  state_r <= ALUWB;
        ALUWB:    state_r <= FETCH;
        BRANCH:   state_r <= FETCH;
        ADDIEXEC: state_r <= ADDIWB;
        ADDIWB:   state_r <= FETCH;
        JUMP:     state_r <= FETCH;
        default:  state_r <= FETCH;
      endcase
    end
  end

  assign state = state_r;

  // Output decode: everything defaults low, each state raises only its own
  // controls. Encodings 12-15 leave every output at 0.
  always_comb begin
    iord       = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    pcen       = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    illegal_op = 1'b0;
    pcsrc      = 2'b00;
    alusrcb    = 2'b00;
    alucontrol = 3'b000;
    case (state_r)
      FETCH: begin
        memread    = 1'b1;
        alusrcb    = 2'b01;
        alucontrol = 3'b010;
        // IR load and PC+4 commit only when the fetch actually completes.
        irwrite    = mem_ready;
        pcen       = mem_ready;
      end
      DECODE: begin
        alusrcb    = 2'b11;
        alucontrol = 3'b010;
        illegal_op = ~op_legal(opcode);
      end
      MEMADR, ADDIEXEC: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = 3'b010;
      end
      MEMRD: begin
        iord    = 1'b1;
        memread = 1'b1;
      end
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      EXECUTE: begin
        alusrca    = 1'b1;
        alucontrol = alu_decode(funct);
      end
      ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = 3'b110;
        pcsrc      = 2'b01;
        pcen       = zero;
      end
      ADDIWB: begin
        regwrite = 1'b1;
      end
      JUMP: begin
        pcsrc = 2'b10;
        pcen  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed instruction traces expanded into a
// per-cycle queue of stimulus plus expected output vectors; a compare process
// checks the DUT against the current vector on each falling edge.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       iord, memread, memwrite, irwrite, pcen, regwrite, regdst;
  logic       memtoreg, alusrca, illegal_op;
  logic [1:0] pcsrc, alusrcb;
  logic [2:0] alucontrol;
  logic [3:0] state;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .iord(iord), .memread(memread), .memwrite(memwrite),
    .irwrite(irwrite), .pcen(pcen), .regwrite(regwrite), .regdst(regdst),
    .memtoreg(memtoreg), .alusrca(alusrca), .illegal_op(illegal_op),
    .pcsrc(pcsrc), .alusrcb(alusrcb), .alucontrol(alucontrol), .state(state)
  );

  typedef struct packed {
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       pcen;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic       illegal_op;
    logic [1:0] pcsrc;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic [3:0] state;
  } out_t;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        rdy;
    logic        chk;
    out_t        exp;
    logic [63:0] tag;
  } vec_t;

  vec_t q[$];
  vec_t cur;
  int   cur_idx;
  logic active = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  out_t dut_o;

  always_comb begin
    dut_o            = '0;
    dut_o.iord       = iord;
    dut_o.memread    = memread;
    dut_o.memwrite   = memwrite;
    dut_o.irwrite    = irwrite;
    dut_o.pcen       = pcen;
    dut_o.regwrite   = regwrite;
    dut_o.regdst     = regdst;
    dut_o.memtoreg   = memtoreg;
    dut_o.alusrca    = alusrca;
    dut_o.illegal_op = illegal_op;
    dut_o.pcsrc      = pcsrc;
    dut_o.alusrcb    = alusrcb;
    dut_o.alucontrol = alucontrol;
    dut_o.state      = state;
  end

  // Expected control word for each instruction step.
  function automatic out_t o_fetch(input logic rdy);
    out_t o = '0;
    o.memread = 1'b1; o.alusrcb = 2'b01; o.alucontrol = 3'b010;
    o.irwrite = rdy;  o.pcen = rdy;      o.state = 4'd0;
    return o;
  endfunction
  function automatic out_t o_decode(input logic ill);
    out_t o = '0;
    o.alusrcb = 2'b11; o.alucontrol = 3'b010; o.illegal_op = ill; o.state = 4'd1;
    return o;
  endfunction
  function automatic out_t o_memadr();
    out_t o = '0;
    o.alusrca = 1'b1; o.alusrcb = 2'b10; o.alucontrol = 3'b010; o.state = 4'd2;
    return o;
  endfunction
  function automatic out_t o_memrd();
    out_t o = '0;
    o.iord = 1'b1; o.memread = 1'b1; o.state = 4'd3;
    return o;
  endfunction
  function automatic out_t o_memwb();
    out_t o = '0;
    o.regwrite = 1'b1; o.memtoreg = 1'b1; o.state = 4'd4;
    return o;
  endfunction
  function automatic out_t o_memwr();
    out_t o = '0;
    o.iord = 1'b1; o.memwrite = 1'b1; o.state = 4'd5;
    return o;
  endfunction
  function automatic out_t o_exec(input logic [2:0] alu);
    out_t o = '0;
    o.alusrca = 1'b1; o.alusrcb = 2'b00; o.alucontrol = alu; o.state = 4'd6;
    return o;
  endfunction
  function automatic out_t o_aluwb();
    out_t o = '0;
    o.regwrite = 1'b1; o.regdst = 1'b1; o.state = 4'd7;
    return o;
  endfunction
  function automatic out_t o_branch(input logic z);
    out_t o = '0;
    o.alusrca = 1'b1; o.alucontrol = 3'b110; o.pcsrc = 2'b01; o.pcen = z;
    o.state = 4'd8;
    return o;
  endfunction
  function automatic out_t o_addiexec();
    out_t o = '0;
    o.alusrca = 1'b1; o.alusrcb = 2'b10; o.alucontrol = 3'b010; o.state = 4'd9;
    return o;
  endfunction
  function automatic out_t o_addiwb();
    out_t o = '0;
    o.regwrite = 1'b1; o.state = 4'd10;
    return o;
  endfunction
  function automatic out_t o_jump();
    out_t o = '0;
    o.pcsrc = 2'b10; o.pcen = 1'b1; o.state = 4'd11;
    return o;
  endfunction

  task automatic push(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic rdy, input logic chk,
                      input out_t e, input logic [63:0] tag);
    vec_t v;
    v.rst = rst; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy;
    v.chk = chk; v.exp = e; v.tag = tag;
    q.push_back(v);
  endtask

  // Expand one instruction into its cycle-by-cycle trace. fst/mst are the
  // number of not-ready cycles inserted in FETCH and in the data access.
  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int fst, input int mst, input logic [2:0] alu,
                       input logic [63:0] tag);
    for (int k = 0; k < fst; k++) push(0, op, fn, z, 0, 1, o_fetch(0), tag);
    push(0, op, fn, z, 1, 1, o_fetch(1), tag);
    case (op)
      6'b100011: begin
        push(0, op, fn, z, 1, 1, o_decode(0), tag);
        push(0, op, fn, z, 1, 1, o_memadr(), tag);
        for (int k = 0; k < mst; k++) push(0, op, fn, z, 0, 1, o_memrd(), tag);
        push(0, op, fn, z, 1, 1, o_memrd(), tag);
        push(0, op, fn, z, 1, 1, o_memwb(), tag);
      end
      6'b101011: begin
        push(0, op, fn, z, 1, 1, o_decode(0), tag);
        push(0, op, fn, z, 1, 1, o_memadr(), tag);
        for (int k = 0; k < mst; k++) push(0, op, fn, z, 0, 1, o_memwr(), tag);
        push(0, op, fn, z, 1, 1, o_memwr(), tag);
      end
      6'b000000: begin
        push(0, op, fn, z, 1, 1, o_decode(0), tag);
        push(0, op, fn, z, 1, 1, o_exec(alu), tag);
        push(0, op, fn, z, 1, 1, o_aluwb(), tag);
      end
      6'b000100: begin
        push(0, op, fn, z, 1, 1, o_decode(0), tag);
        push(0, op, fn, z, 1, 1, o_branch(z), tag);
      end
      6'b001000: begin
        push(0, op, fn, z, 1, 1, o_decode(0), tag);
        push(0, op, fn, z, 1, 1, o_addiexec(), tag);
        push(0, op, fn, z, 1, 1, o_addiwb(), tag);
      end
      6'b000010: begin
        push(0, op, fn, z, 1, 1, o_decode(0), tag);
        push(0, op, fn, z, 1, 1, o_jump(), tag);
      end
      default: push(0, op, fn, z, 1, 1, o_decode(1), tag);
    endcase
  endtask

  task automatic pin(input logic [63:0] name, input out_t got, input out_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL pin_%0s got=%h want=%h", name, got, exp);
    end
  endtask

  // Compare process: outputs are combinational, so check mid-cycle.
  always @(negedge clk) begin
    if (active && cur.chk) begin
      n_cmp++;
      if (dut_o !== cur.exp) begin
        n_bad++;
        $display("FAIL %0s vec%0d got=%h want=%h (state got %0d want %0d)",
                 cur.tag, cur_idx, dut_o, cur.exp, dut_o.state, cur.exp.state);
      end
    end
  end

  initial begin
    reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;

    // Hand-computed control words pinning the expectation table.
    pin("fetch1", o_fetch(1),       21'hB00A0);
    pin("memwb",  o_memwb(),        21'h0A004);
    pin("branch", o_branch(1),      21'h11268);
    pin("execslt", o_exec(3'b111),  21'h01076);
    pin("jump",   o_jump(),         21'h1040B);

    // Reset: first cycle state is unknown, second must already be FETCH.
    push(1, 6'b100011, 6'b0, 0, 0, 0, o_fetch(0), "rst0");
    push(1, 6'b100011, 6'b0, 0, 0, 1, o_fetch(0), "rst1");

    instr(6'b100011, 6'b000000, 0, 0, 0, 3'b010, "lw");
    instr(6'b000000, 6'b101010, 0, 0, 0, 3'b111, "slt");
    instr(6'b000000, 6'b100000, 0, 0, 0, 3'b010, "add");
    instr(6'b000000, 6'b100010, 0, 0, 0, 3'b110, "sub");
    instr(6'b000000, 6'b100100, 0, 0, 0, 3'b000, "and");
    instr(6'b000000, 6'b100101, 0, 0, 0, 3'b001, "or");
    instr(6'b000000, 6'b000111, 0, 0, 0, 3'b010, "rdflt");
    instr(6'b000100, 6'b000000, 1, 0, 0, 3'b000, "beq_t");
    instr(6'b000100, 6'b000000, 0, 0, 0, 3'b000, "beq_n");
    instr(6'b001000, 6'b000000, 0, 0, 0, 3'b000, "addi");
    instr(6'b000010, 6'b000000, 0, 0, 0, 3'b000, "j");
    instr(6'b101011, 6'b000000, 0, 2, 3, 3'b000, "sw_stl");
    instr(6'b100011, 6'b000000, 0, 1, 2, 3'b000, "lw_stl");
    instr(6'b111111, 6'b000000, 0, 0, 0, 3'b000, "ill3f");
    instr(6'b000011, 6'b000000, 0, 0, 0, 3'b000, "ill03");

    // Reset in MEMRD while memory completes: must not reach MEMWB.
    push(0, 6'b100011, 6'b0, 0, 1, 1, o_fetch(1), "rst_mrd");
    push(0, 6'b100011, 6'b0, 0, 1, 1, o_decode(0), "rst_mrd");
    push(0, 6'b100011, 6'b0, 0, 1, 1, o_memadr(), "rst_mrd");
    push(1, 6'b100011, 6'b0, 0, 1, 1, o_memrd(), "rst_mrd");
    push(0, 6'b100011, 6'b0, 0, 0, 1, o_fetch(0), "rst_mrd");
    push(0, 6'b100011, 6'b0, 0, 1, 1, o_fetch(1), "rst_mrd");
    push(0, 6'b100011, 6'b0, 0, 1, 1, o_decode(0), "rst_mrd");
    push(1, 6'b100011, 6'b0, 0, 1, 1, o_memadr(), "rst_mad");
    push(0, 6'b101011, 6'b0, 0, 1, 1, o_fetch(1), "rst_mad");
    // Reset mid-MEMWR stall.
    push(0, 6'b101011, 6'b0, 0, 1, 1, o_decode(0), "rst_mwr");
    push(0, 6'b101011, 6'b0, 0, 1, 1, o_memadr(), "rst_mwr");
    push(0, 6'b101011, 6'b0, 0, 0, 1, o_memwr(), "rst_mwr");
    push(1, 6'b101011, 6'b0, 0, 0, 1, o_memwr(), "rst_mwr");
    push(0, 6'b101011, 6'b0, 0, 0, 1, o_fetch(0), "rst_mwr");
    // Reset while FETCH completes: must stay in FETCH.
    push(1, 6'b000000, 6'b100000, 0, 1, 1, o_fetch(1), "rst_fch");
    push(0, 6'b000000, 6'b100000, 0, 1, 1, o_fetch(1), "rst_fch");
    // Reset in DECODE of an R-type.
    push(1, 6'b000000, 6'b100000, 0, 1, 1, o_decode(0), "rst_dec");
    push(0, 6'b000000, 6'b100000, 0, 0, 1, o_fetch(0), "rst_dec");
    instr(6'b100011, 6'b000000, 0, 0, 0, 3'b000, "lw_end");

    for (int i = 0; i < q.size(); i++) begin
      @(posedge clk);
      #1;
      reset = q[i].rst; opcode = q[i].op; funct = q[i].fn;
      zero = q[i].z; mem_ready = q[i].rdy;
      cur = q[i]; cur_idx = i; active = 1'b1;
    end
    @(posedge clk);
    #1;
    active = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 opcode  input  6  Instr[31:26] from the datapath instruction register; stable from the cycle after FETCH completes.
REQ-005 funct  input  6  Instr[5:0] from the instruction register.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 mem_ready  input  1  unified memory completion strobe for the current access.
REQ-008 The block SHALL provide these 1-bit outputs: iord, memread, memwrite, irwrite, pcen, regwrite, regdst, memtoreg, alusrca, illegal_op.
REQ-009 pcsrc  output  2  PC mux select: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-010 alusrcb  output  2  ALU B select: 00 rt, 01 constant 4, 10 sign-extended imm, 11 imm<<2.
REQ-011 alucontrol  output  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-012 state  output  4  current state encoding, for debug and verification.

Function
REQ-013 The FSM SHALL use these states and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11.
REQ-014 Encodings 12-15 SHALL transition to FETCH on the next edge, with all outputs 0.
REQ-015 FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00.
REQ-016 FETCH: irwrite=pcen=mem_ready; stay in FETCH while mem_ready=0, go to DECODE when mem_ready=1.
REQ-017 DECODE: alusrca=0, alusrcb=11, alucontrol=010.
REQ-018 DECODE next state: lw(100011)/sw(101011) -> MEMADR; R-type(000000) -> EXECUTE; beq(000100) -> BRANCH; addi(001000) -> ADDIEXEC; j(000010) -> JUMP.
REQ-019 DECODE with any other opcode SHALL drive illegal_op=1 for that cycle and go to FETCH.
REQ-020 MEMADR: alusrca=1, alusrcb=10, alucontrol=010; next state MEMRD for lw, MEMWR for sw.
REQ-021 MEMRD: iord=1, memread=1; hold until mem_ready=1, then go to MEMWB.
REQ-022 MEMWB: regwrite=1, regdst=0, memtoreg=1; next state FETCH.
REQ-023 MEMWR: iord=1, memwrite=1; memwrite stays high every cycle until mem_ready=1, then go to FETCH.
REQ-024 EXECUTE: alusrca=1, alusrcb=00; alucontrol decoded from funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, other->010; next state ALUWB.
REQ-025 ALUWB: regwrite=1, regdst=1, memtoreg=0; next state FETCH.
REQ-026 BRANCH: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, pcen=zero; next state FETCH.
REQ-027 ADDIEXEC: alusrca=1, alusrcb=10, alucontrol=010; next state ADDIWB.
REQ-028 ADDIWB: regwrite=1, regdst=0, memtoreg=0; next state FETCH.
REQ-029 JUMP: pcsrc=10, pcen=1; next state FETCH.
REQ-030 Any output not listed for a state SHALL be 0 in that state.
REQ-031 All outputs SHALL be combinational functions of state, opcode, funct, zero and mem_ready only, with no latches.
REQ-032 Instruction latency with mem_ready tied to 1: lw 5 cycles; sw, R-type and addi 4; beq and j 3.

Reset
REQ-033 reset=1 at a rising edge SHALL force state=FETCH, overriding every pending transition, including mid-MEMWR and mid-stall.
REQ-034 While in FETCH after reset, outputs SHALL be exactly the REQ-015/016 values; no regwrite or memwrite SHALL occur during or after the reset cycle.
REQ-035 Reset SHALL have no effect between clock edges.

Verification
REQ-036 mem_ready=1, opcode=100011: states 0,1,2,3,4,0; regwrite=1 only in state 4, with memtoreg=1.
REQ-037 opcode=000000, funct=101010: states 0,1,6,7,0; alucontrol=111 in EXECUTE; regwrite=1 and regdst=1 in ALUWB.
REQ-038 beq (000100): with zero=1, pcen=1 and pcsrc=01 in BRANCH; with zero=0, pcen=0; both cases return to FETCH.
REQ-039 sw with mem_ready low for 3 cycles in MEMWR: memwrite=1 for 4 consecutive cycles, then FETCH; FETCH with mem_ready=0 gives irwrite=pcen=0 and state held.
REQ-040 opcode=111111 in DECODE gives illegal_op=1 for one cycle, then FETCH; reset asserted in MEMRD gives state=0 on the next edge.
